// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//   Multi-channel button debouncer for the game's button bank.
//   Each raw input passes through a 2-FF synchroniser. It is then sampled on
//   a shared divided tick. A new level is accepted only after STABLE_CNT
//   consecutive samples that all differ from the current debounced level.
//
//   Optional build macro: DEBOUNCE_REPEAT_EN
//     When defined, each channel gets a hold-to-repeat pulse generator.
//     When undefined, no repeat logic is built and REPEAT is tied to 0.
//
// Ports
//   CLK      in   1     system clock
//   RST      in   1     asynchronous, active-high reset
//   BTNIN    in   N_CH  raw, asynchronous button inputs
//   LEVEL    out  N_CH  debounced level
//   PRESS    out  N_CH  one-CLK pulse on an accepted 0->1
//   RELEASE  out  N_CH  one-CLK pulse on an accepted 1->0
//   REPEAT   out  N_CH  one-CLK auto-repeat pulse (0 without the macro)
//   TICK     out  1     sample strobe, one CLK wide
// ---------------------------------------------------------------------------
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_CNT   = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTNIN,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] REPEAT,
  output logic            TICK
);

  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam int SCNT_W = $clog2(STABLE_CNT + 1);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CNT - 1);

  // Reject configurations the counters cannot represent.
  if (N_CH < 1 || TICK_DIV < 2 || STABLE_CNT < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("debounce_multi: illegal parameter value");
  end

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [N_CH-1:0]   sync1_q, sync2_q;
  logic [N_CH-1:0]   level_q, level_d;
  logic [N_CH-1:0]   press_q, press_d;
  logic [N_CH-1:0]   release_q, release_d;
  logic [SCNT_W-1:0] scnt_q [N_CH];
  logic [SCNT_W-1:0] scnt_d [N_CH];
  logic              tick_s;
  logic [N_CH-1:0]   accept_s;

  // Tick divider next state and the shared sample strobe.
  always_comb begin
    tick_s = (tcnt_q == TCNT_LAST);
    if (tick_s) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
  end

  // Per-channel stability counting and level acceptance.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    scnt_d    = scnt_q;
    accept_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!tick_s) begin
        scnt_d[i] = scnt_q[i];
      end else if (sync2_q[i] == level_q[i]) begin
        // Any agreeing sample cancels a pending change (bounce rejection).
        scnt_d[i] = '0;
      end else if (scnt_q[i] == SCNT_LAST) begin
        scnt_d[i]    = '0;
        level_d[i]   = sync2_q[i];
        accept_s[i]  = 1'b1;
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        scnt_d[i] = scnt_q[i] + SCNT_W'(1);
      end
    end
  end

  // Divider, synchroniser, debounced level and press/release pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        scnt_q[i] <= '0;
      end
    end else begin
      tcnt_q    <= tcnt_d;
      sync1_q   <= BTNIN;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      scnt_q    <= scnt_d;
    end
  end

  assign TICK    = tick_s;
  assign LEVEL   = level_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [RCNT_W-1:0] RCNT_DELAY = RCNT_W'(REPEAT_DELAY);
  // When REPEAT_RATE > REPEAT_DELAY this is a wrapped (modular) value.
  // Counting up from it still reaches REPEAT_DELAY after exactly
  // REPEAT_RATE ticks, because the counter modulus exceeds REPEAT_RATE.
  localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [RCNT_W-1:0] rcnt_q [N_CH];
  logic [RCNT_W-1:0] rcnt_d [N_CH];
  logic [RCNT_W-1:0] rnext_s [N_CH];
  logic [N_CH-1:0]   repeat_q, repeat_d;

  // Hold-to-repeat counters. The accept cycle never increments, so the
  // RELEASE cycle can never raise REPEAT.
  always_comb begin
    rcnt_d   = rcnt_q;
    repeat_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      rnext_s[i] = rcnt_q[i] + RCNT_W'(1);
      if (!level_q[i]) begin
        // Covers the PRESS cycle too: LEVEL is still 0 when it is accepted.
        rcnt_d[i] = '0;
      end else if (tick_s && !accept_s[i]) begin
        if (rnext_s[i] == RCNT_DELAY) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = RCNT_RELOAD;
        end else begin
          rcnt_d[i] = rnext_s[i];
        end
      end else begin
        rcnt_d[i] = rcnt_q[i];
      end
    end
  end

  // Repeat counter and pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      repeat_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rcnt_q[i] <= '0;
      end
    end else begin
      repeat_q <= repeat_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign REPEAT = repeat_q;
`else
  assign REPEAT = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
//   Directed plus randomised stimulus against a behavioural model of the
//   debouncer: a two-sample input delay, a tick every TD cycles, a run length
//   of differing samples per channel, and ticks-since-press for repeat.
// ---------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [N-1:0] BTNIN = '0;
  logic [N-1:0] LEVEL, PRESS, RELEASE, REPEAT;
  logic         TICK;

  debounce_multi #(
    .N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLK(CLK), .RST(RST), .BTNIN(BTNIN),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE),
    .REPEAT(REPEAT), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int           m_edges;
  logic [N-1:0] seen_new, seen_old;
  logic [N-1:0] m_level, m_press, m_rel, m_rep;
  int           m_run  [N];
  int           m_held [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges  = 0;
    seen_new = '0;
    seen_old = '0;
    m_level  = '0;
    m_press  = '0;
    m_rel    = '0;
    m_rep    = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  // Advance the model across one rising edge using pre-edge values.
  task automatic model_edge();
    logic [N-1:0] smp;
    logic         tk;
    logic         acc;
    smp     = seen_old;
    tk      = ((m_edges % TD) == TD - 1);
    m_press = '0;
    m_rel   = '0;
    m_rep   = '0;
    if (tk) begin
      for (int c = 0; c < N; c++) begin
        acc = 1'b0;
        if (smp[c] == m_level[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == SC) begin
            m_run[c]   = 0;
            m_level[c] = smp[c];
            acc        = 1'b1;
            if (smp[c]) begin
              m_press[c] = 1'b1;
              m_held[c]  = 0;
            end else begin
              m_rel[c] = 1'b1;
            end
          end
        end
        if (!acc && m_level[c]) begin
          m_held[c]++;
`ifdef DEBOUNCE_REPEAT_EN
          if (m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0) m_rep[c] = 1'b1;
`endif
        end
      end
    end
    seen_old = seen_new;
    seen_new = BTNIN;
    m_edges++;
  endtask

  // One clock with input v, then compare every output against the model.
  task automatic cyc(input logic [N-1:0] v);
    @(negedge CLK);
    BTNIN = v;
    @(posedge CLK);
    model_edge();
    #1;
    chk("LEVEL",   32'(LEVEL),   32'(m_level));
    chk("PRESS",   32'(PRESS),   32'(m_press));
    chk("RELEASE", 32'(RELEASE), 32'(m_rel));
    chk("REPEAT",  32'(REPEAT),  32'(m_rep));
    chk("TICK",    32'(TICK),    32'((m_edges % TD) == TD - 1));
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    for (int k = 0; k < n; k++) cyc(v);
  endtask

  // Asynchronous mid-cycle reset pulse spanning two rising edges.
  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("RST_LEVEL",   32'(LEVEL),   32'd0);
    chk("RST_PRESS",   32'(PRESS),   32'd0);
    chk("RST_RELEASE", 32'(RELEASE), 32'd0);
    chk("RST_REPEAT",  32'(REPEAT),  32'd0);
    chk("RST_TICK",    32'(TICK),    32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      chk("RST_HOLD_LEVEL", 32'(LEVEL), 32'd0);
      chk("RST_HOLD_TICK",  32'(TICK),  32'd0);
    end
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] rv;
    int           rn;
    model_reset();

    do_reset();
    hold(4'b0001, 20);                  // clean press on ch0
    do_reset();                         // async reset with LEVEL=1
    hold(4'b0001, 20);

    for (int i = 0; i < 10; i++) begin  // ch1 toggles every tick
      hold({2'b00, i[0], 1'b1}, TD);
    end
    hold(4'b0011, 20);                  // then ch1 held

    hold(4'b0001, 20);                  // release ch1
    hold(4'b0000, 20);                  // release ch0
    hold(4'b1100, 20);                  // simultaneous press ch2/ch3
    hold(4'b0000, 20);

    hold(4'b0001, 2 * TD);              // pending press discarded by reset
    do_reset();
    hold(4'b0001, 20);

    hold(4'b0100, 60);                  // long hold on ch2 (repeat)
    hold(4'b0000, 20);

    for (int r = 0; r < 40; r++) begin
      rv = 4'($urandom);
      rn = $urandom_range(1, 24);
      hold(rv, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
